// File: rtl/alarm_sequencer.sv
// Alarm clock buzzer sequencer: arms on enable, rings on time match, handles
// snooze/stop keys, auto-off timeout and re-arming once the matching minute passes.
module alarm_sequencer #(
    parameter logic [7:0] RING_TIMEOUT_SECS = 8'd60,
    parameter logic [7:0] SNOOZE_SECS       = 8'd120,
    parameter logic [3:0] MAX_SNOOZES       = 4'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        one_second,
    input  logic [15:0] curr_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        load_alarm,
    input  logic        snooze_key,
    input  logic        stop_key,
    output logic        alarm_sound,
    output logic        snoozing,
    output logic [3:0]  snooze_count_out,
    output logic [2:0]  debug_state_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        RINGING = 3'd2,
        SNOOZE  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [7:0]  timer, timer_next;
    logic [3:0]  snooze_cnt, snooze_cnt_next;
    logic        time_match;

    assign time_match = (curr_time == alarm_time);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            snooze_cnt <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            snooze_cnt <= snooze_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        timer_next      = timer;
        snooze_cnt_next = snooze_cnt;

        // Default countdown; any load assigned below overrides it in the same clock.
        if (one_second && (state == RINGING || state == SNOOZE) && timer != '0)
            timer_next = timer - 8'd1;

        if (!alarm_enable) begin
            state_next = IDLE;
        end else if (load_alarm) begin
            state_next = DONE;
        end else begin
            case (state)
                IDLE: state_next = ARMED;
                ARMED: begin
                    if (time_match) begin
                        state_next      = RINGING;
                        timer_next      = RING_TIMEOUT_SECS;
                        snooze_cnt_next = '0;
                    end
                end
                RINGING: begin
                    if (stop_key) begin
                        state_next = DONE;
                    end else if (snooze_key && snooze_cnt < MAX_SNOOZES) begin
                        state_next      = SNOOZE;
                        timer_next      = SNOOZE_SECS;
                        snooze_cnt_next = snooze_cnt + 4'd1;
                    end else if (timer == '0) begin
                        state_next = DONE;
                    end
                end
                SNOOZE: begin
                    if (stop_key) begin
                        state_next = DONE;
                    end else if (timer == '0) begin
                        state_next = RINGING;
                        timer_next = RING_TIMEOUT_SECS;
                    end
                end
                DONE: begin
                    if (!time_match)
                        state_next = ARMED;
                end
                default: state_next = IDLE;
            endcase
        end

        // Unused encodings recover to IDLE regardless of enable/load.
        if (state != IDLE && state != ARMED && state != RINGING &&
            state != SNOOZE && state != DONE)
            state_next = IDLE;
    end

    assign alarm_sound      = (state == RINGING);
    assign snoozing         = (state == SNOOZE);
    assign snooze_count_out = snooze_cnt;
    assign debug_state_out  = state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer with short timeouts
// (ring 5 s, snooze 3 s, 2 snoozes per event).
module tb_alarm_sequencer;

    logic        clk;
    logic        reset_n;
    logic        one_second;
    logic [15:0] curr_time;
    logic [15:0] alarm_time;
    logic        alarm_enable;
    logic        load_alarm;
    logic        snooze_key;
    logic        stop_key;
    logic        alarm_sound;
    logic        snoozing;
    logic [3:0]  snooze_count_out;
    logic [2:0]  debug_state_out;

    int checks = 0;
    int errors = 0;

    alarm_sequencer #(
        .RING_TIMEOUT_SECS(8'd5),
        .SNOOZE_SECS(8'd3),
        .MAX_SNOOZES(4'd2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .one_second(one_second),
        .curr_time(curr_time),
        .alarm_time(alarm_time),
        .alarm_enable(alarm_enable),
        .load_alarm(load_alarm),
        .snooze_key(snooze_key),
        .stop_key(stop_key),
        .alarm_sound(alarm_sound),
        .snoozing(snoozing),
        .snooze_count_out(snooze_count_out),
        .debug_state_out(debug_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick edge followed by one quiet edge.
    task automatic tick();
        one_second = 1'b1;
        step();
        one_second = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL reset_sound: got %0b expected 0", alarm_sound); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing: got %0b expected 0", snoozing); end
        checks++; if (snooze_count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", snooze_count_out); end
        checks++; if (debug_state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", debug_state_out); end
        alarm_enable = 1'b1;
        reset_n = 1'b1;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL idle_to_armed: got %0d expected 1", debug_state_out); end
        snooze_key = 1'b1; stop_key = 1'b1;
        step();
        snooze_key = 1'b0; stop_key = 1'b0;
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL keys_ignored_armed: got %0d expected 1", debug_state_out); end
    endtask

    task automatic test_auto_off();
        curr_time = 16'h0700;
        step();
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL ring_start_sound: got %0b expected 1", alarm_sound); end
        checks++; if (debug_state_out !== 3'd2) begin errors++; $display("FAIL ring_start_state: got %0d expected 2", debug_state_out); end
        checks++; if (snooze_count_out !== 4'd0) begin errors++; $display("FAIL ring_start_count: got %0d expected 0", snooze_count_out); end
        repeat (4) tick();
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL ring_after_4_ticks: got %0b expected 1", alarm_sound); end
        tick();
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL auto_off_sound: got %0b expected 0", alarm_sound); end
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL auto_off_state: got %0d expected 4", debug_state_out); end
        step();
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL done_holds_in_minute: got %0d expected 4", debug_state_out); end
        curr_time = 16'h0701;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL done_rearm: got %0d expected 1", debug_state_out); end
    endtask

    task automatic test_snooze();
        curr_time = 16'h0700;
        step();
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze1_flag: got %0b expected 1", snoozing); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL snooze1_sound: got %0b expected 0", alarm_sound); end
        checks++; if (snooze_count_out !== 4'd1) begin errors++; $display("FAIL snooze1_count: got %0d expected 1", snooze_count_out); end
        repeat (2) tick();
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze_after_2_ticks: got %0b expected 1", snoozing); end
        tick();
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL snooze_expire_sound: got %0b expected 1", alarm_sound); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL snooze_expire_flag: got %0b expected 0", snoozing); end
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        checks++; if (snooze_count_out !== 4'd2) begin errors++; $display("FAIL snooze2_count: got %0d expected 2", snooze_count_out); end
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze2_flag: got %0b expected 1", snoozing); end
        repeat (3) tick();
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL snooze3_ignored_sound: got %0b expected 1", alarm_sound); end
        checks++; if (debug_state_out !== 3'd2) begin errors++; $display("FAIL snooze3_ignored_state: got %0d expected 2", debug_state_out); end
        checks++; if (snooze_count_out !== 4'd2) begin errors++; $display("FAIL snooze3_saturate: got %0d expected 2", snooze_count_out); end
        stop_key = 1'b1;
        step();
        stop_key = 1'b0;
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL stop_state: got %0d expected 4", debug_state_out); end
        curr_time = 16'h0701;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL snooze_rearm_state: got %0d expected 1", debug_state_out); end
        checks++; if (snooze_count_out !== 4'd2) begin errors++; $display("FAIL count_kept_armed: got %0d expected 2", snooze_count_out); end
    endtask

    task automatic test_stop_beats_snooze();
        curr_time = 16'h0700;
        step();
        checks++; if (snooze_count_out !== 4'd0) begin errors++; $display("FAIL count_cleared_on_ring: got %0d expected 0", snooze_count_out); end
        snooze_key = 1'b1; stop_key = 1'b1;
        step();
        snooze_key = 1'b0; stop_key = 1'b0;
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL stop_snooze_state: got %0d expected 4", debug_state_out); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL stop_snooze_sound: got %0b expected 0", alarm_sound); end
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL stop_snooze_flag: got %0b expected 0", snoozing); end
        checks++; if (snooze_count_out !== 4'd0) begin errors++; $display("FAIL stop_snooze_count: got %0d expected 0", snooze_count_out); end
        curr_time = 16'h0701;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL stop_snooze_rearm: got %0d expected 1", debug_state_out); end
    endtask

    task automatic test_load_alarm();
        curr_time = 16'h1230; alarm_time = 16'h1230; load_alarm = 1'b1;
        step();
        load_alarm = 1'b0;
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL load_state: got %0d expected 4", debug_state_out); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL load_sound: got %0b expected 0", alarm_sound); end
        step();
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL load_no_ring: got %0b expected 0", alarm_sound); end
        curr_time = 16'h1231;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL load_rearm: got %0d expected 1", debug_state_out); end
    endtask

    task automatic test_disable_and_reset();
        curr_time = 16'h1230;
        step();
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL dis_ring_sound: got %0b expected 1", alarm_sound); end
        alarm_enable = 1'b0;
        step();
        checks++; if (debug_state_out !== 3'd0) begin errors++; $display("FAIL disable_state: got %0d expected 0", debug_state_out); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL disable_sound: got %0b expected 0", alarm_sound); end
        alarm_enable = 1'b1;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL reenable_state: got %0d expected 1", debug_state_out); end
        step();
        snooze_key = 1'b1;
        step();
        snooze_key = 1'b0;
        checks++; if (snoozing !== 1'b1) begin errors++; $display("FAIL pre_reset_snoozing: got %0b expected 1", snoozing); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (snoozing !== 1'b0) begin errors++; $display("FAIL async_reset_snoozing: got %0b expected 0", snoozing); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL async_reset_sound: got %0b expected 0", alarm_sound); end
        checks++; if (snooze_count_out !== 4'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", snooze_count_out); end
        checks++; if (debug_state_out !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", debug_state_out); end
        step();
        #2 reset_n = 1'b1;
        curr_time = 16'h1231;
        step();
        checks++; if (debug_state_out !== 3'd1) begin errors++; $display("FAIL post_reset_armed: got %0d expected 1", debug_state_out); end
    endtask

    task automatic test_coincident_tick();
        curr_time = 16'h1230; one_second = 1'b1;
        step();
        one_second = 1'b0;
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL coinc_ring_start: got %0b expected 1", alarm_sound); end
        repeat (4) tick();
        checks++; if (alarm_sound !== 1'b1) begin errors++; $display("FAIL coinc_after_4_ticks: got %0b expected 1", alarm_sound); end
        tick();
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL coinc_after_5_ticks: got %0b expected 0", alarm_sound); end
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL coinc_done_state: got %0d expected 4", debug_state_out); end
        repeat (2) tick();
        checks++; if (debug_state_out !== 3'd4) begin errors++; $display("FAIL coinc_no_wrap_state: got %0d expected 4", debug_state_out); end
        checks++; if (alarm_sound !== 1'b0) begin errors++; $display("FAIL coinc_no_wrap_sound: got %0b expected 0", alarm_sound); end
    endtask

    initial begin
        reset_n      = 1'b0;
        one_second   = 1'b0;
        curr_time    = 16'h0659;
        alarm_time   = 16'h0700;
        alarm_enable = 1'b0;
        load_alarm   = 1'b0;
        snooze_key   = 1'b0;
        stop_key     = 1'b0;

        test_reset();
        test_auto_off();
        test_snooze();
        test_stop_beats_snooze();
        test_load_alarm();
        test_disable_and_reset();
        test_coincident_tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
